// File: rtl/sd_init_sequencer.sv
// SD card identification/initialization sequencer: walks CMD0..ACMD6 through the CMD line
// driver, latches the RCA and reports ready or a coded error.
module sd_init_sequencer #(
    parameter int unsigned ACMD41_RETRIES = 1000,
    parameter int unsigned RESP_TIMEOUT   = 65535
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    output logic         osend,
    output logic [5:0]   ocmd_index,
    output logic [31:0]  ocmd_arg,
    input  logic [135:0] iresp,
    input  logic         icrc_failed,
    input  logic         idone,
    output logic [15:0]  orca,
    output logic         oready,
    output logic         oerror,
    output logic [2:0]   oerr_code
);

    localparam logic [15:0] TMO_LAST   = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] RETRY_LAST = 16'(ACMD41_RETRIES - 1);

    typedef enum logic [3:0] {
        StIdle, StC0, StC8, StC55a, StA41, StC2, StC3, StC7, StC55b, StA6, StReady, StError
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  err_q, err_d;
    logic [15:0] rca_q, rca_d;
    logic [15:0] retry_q, retry_d;
    logic [15:0] tmo_q;
    logic        send_q;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d;
    logic        issue;

    // Only the argument field and R6 RCA bits of the response are consumed.
    logic unused_resp;
    assign unused_resp = ^{iresp[135:40], iresp[23:20], iresp[7:0]};

    function automatic logic is_issue(input state_e s);
        return !(s inside {StIdle, StReady, StError});
    endfunction

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rca_d   = rca_q;
        retry_d = retry_q;
        if (!is_issue(state_q)) begin
            if (istart) begin
                state_d = StC0;
                err_d   = '0;
                rca_d   = '0;
                retry_d = '0;
            end
        end else if (idone) begin
            // R3 (ACMD41) carries no valid CRC; CMD0 has no response at all.
            if (icrc_failed && !(state_q inside {StC0, StA41})) begin
                state_d = StError;
                err_d   = 3'd3;
            end else begin
                case (state_q)
                    StC0:   state_d = StC8;
                    StC8: begin
                        if (iresp[19:8] == 12'h1AA) begin
                            state_d = StC55a;
                        end else begin
                            state_d = StError;
                            err_d   = 3'd1;
                        end
                    end
                    StC55a: state_d = StA41;
                    StA41: begin
                        if (iresp[39]) begin
                            state_d = StC2;
                        end else if (retry_q == RETRY_LAST) begin
                            state_d = StError;
                            err_d   = 3'd2;
                        end else begin
                            retry_d = retry_q + 16'd1;
                            state_d = StC55a;
                        end
                    end
                    StC2:   state_d = StC3;
                    StC3: begin
                        rca_d   = iresp[39:24];
                        state_d = StC7;
                    end
                    StC7:   state_d = StC55b;
                    StC55b: state_d = StA6;
                    StA6:   state_d = StReady;
                    default: state_d = state_q;
                endcase
            end
        end else if (tmo_q == TMO_LAST) begin
            state_d = StError;
            err_d   = (state_q == StA41) ? 3'd5 : 3'd4;
        end
    end

    // Command fields use rca_d so CMD7 picks up the RCA latched on the same edge.
    always_comb begin
        issue = (state_d != state_q) && is_issue(state_d);
        idx_d = '0;
        arg_d = '0;
        case (state_d)
            StC8:   begin idx_d = 6'd8;  arg_d = 32'h0000_01AA;    end
            StC55a: begin idx_d = 6'd55; arg_d = 32'h0;            end
            StA41:  begin idx_d = 6'd41; arg_d = 32'h40FF_8000;    end
            StC2:   begin idx_d = 6'd2;  arg_d = 32'h0;            end
            StC3:   begin idx_d = 6'd3;  arg_d = 32'h0;            end
            StC7:   begin idx_d = 6'd7;  arg_d = {rca_d, 16'h0};   end
            StC55b: begin idx_d = 6'd55; arg_d = {rca_d, 16'h0};   end
            StA6:   begin idx_d = 6'd6;  arg_d = 32'h0000_0002;    end
            default: begin idx_d = 6'd0; arg_d = 32'h0;           end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= StIdle;
            err_q   <= '0;
            rca_q   <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            send_q  <= 1'b0;
            idx_q   <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rca_q   <= rca_d;
            retry_q <= retry_d;
            send_q  <= issue;
            if (issue) begin
                idx_q <= idx_d;
                arg_q <= arg_d;
                tmo_q <= '0;
            end else if (is_issue(state_q)) begin
                tmo_q <= tmo_q + 16'd1;
            end
        end
    end

    // Mask the pulse during the reset cycle itself.
    assign osend      = send_q & ~irst;
    assign ocmd_index = idx_q;
    assign ocmd_arg   = arg_q;
    assign orca       = rca_q;
    assign oready     = (state_q == StReady);
    assign oerror     = (state_q == StError);
    assign oerr_code  = err_q;

endmodule
